fetch_miss_handler: RTL and testbench
=====================================

FETCH_MISS_HANDLER -- requirements
Module: fetch_miss_handler

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: fetch address width in bits.
REQ-002 Parameter DATA_WIDTH, default 64: memory beat and cache write width in bits.
REQ-003 Parameter LINE_BEATS, default 8: beats per cache line (power of two); line is 64 bytes at defaults.
REQ-004 Ports (name  direction  width  meaning):
- clock_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- tagMiss_i  in  1  fetch tag query missed this cycle.
- missAddr_i  in  ADDR_WIDTH  fetch address of the miss.
- tagQueryStall_i  in  1  stall unit confirms the fetch tag-query stage is frozen.
- fetchCacheMissStall_o  out  1  stall request to the stall unit.
- memReq_o  out  1  line refill request to memory.
- memAddr_o  out  ADDR_WIDTH  line-aligned refill address.
- memReqAck_i  in  1  memory accepted the request.
- memDataValid_i  in  1  memData_i carries a valid beat.
- memData_i  in  DATA_WIDTH  refill beat data.
- cacheWriteEn_o  out  1  write one beat into the instruction cache.
- cacheWriteAddr_o  out  ADDR_WIDTH  line address plus beat offset for the write.
- cacheWriteData_o  out  DATA_WIDTH  beat data to write.
- refillDone_o  out  1  one-cycle pulse: line fully written.

Function
REQ-005 States SHALL be IDLE, WAIT_STALL, REQ, FILL, DONE.
REQ-006 IDLE + tagMiss_i=1: capture missAddr_i with beat-offset bits cleared, assert fetchCacheMissStall_o from the next cycle, go to WAIT_STALL.
REQ-007 WAIT_STALL: hold until tagQueryStall_i=1 is sampled on a rising edge, then go to REQ; no memory request is issued before that.
REQ-008 REQ: memReq_o=1 and memAddr_o=captured line address, both held stable until memReqAck_i=1 is sampled; then go to FILL with the beat counter at 0.
REQ-009 FILL: every cycle with memDataValid_i=1 drives cacheWriteEn_o=1 combinationally in the same cycle, with cacheWriteData_o=memData_i and cacheWriteAddr_o=line address + beat*(DATA_WIDTH/8), then increments the beat counter.
REQ-010 The beat counter SHALL be log2(LINE_BEATS) bits wide; the beat equal to LINE_BEATS-1 moves the FSM to DONE without wrap-around reuse.
REQ-011 FILL cycles with memDataValid_i=0 SHALL neither write nor count; gaps of any length are legal.
REQ-012 DONE: refillDone_o=1 for exactly one cycle and fetchCacheMissStall_o=0 in this cycle; the next state is IDLE.
REQ-013 fetchCacheMissStall_o SHALL be 1 in WAIT_STALL, REQ and FILL, and 0 in IDLE and DONE.
REQ-014 tagMiss_i outside IDLE SHALL be ignored; there is no queueing of a second miss.
REQ-015 memDataValid_i outside FILL, including the cycle of memReqAck_i, SHALL be ignored and SHALL NOT write.
REQ-016 Latency: with tagQueryStall_i, memReqAck_i and every data beat at their earliest cycle, a miss at cycle 0 gives stall=1 at cycle 1, memReq_o=1 at cycle 2, beats at cycles 3..10, refillDone_o at cycle 11, and stall=0 from cycle 11.

Reset
REQ-017 reset_i=1 at a rising edge SHALL force IDLE, clear the beat counter and captured address, and drive all outputs to 0 the following cycle.
REQ-018 Reset mid-refill SHALL abandon the line: no further cacheWriteEn_o and no refillDone_o for that miss.

Structure
REQ-019 Package fetch_pkg SHALL hold the FSM state type, LINE_BEATS and the offset-bit-width constant, shared with the fetch stage.
REQ-020 The beat counter with its terminal-count flag SHALL be sub-module refill_beat_counter; all other logic stays in fetch_miss_handler.

Verification
REQ-021 Miss at 0x1000_0044 with tagQueryStall_i, ack and beats back-to-back -> memAddr_o=0x1000_0040; writes at 0x...40 through 0x...78 on cycles 3..10; refillDone_o at cycle 11.
REQ-022 tagQueryStall_i held 0 for 5 cycles -> memReq_o stays 0 and stall stays 1 throughout; request issued the cycle after tagQueryStall_i=1.
REQ-023 memReqAck_i delayed 4 cycles and memDataValid_i=1 during REQ -> memReq_o and memAddr_o stable, no writes before FILL.
REQ-024 Beats with a 2-cycle gap after beat 3, plus tagMiss_i pulsed during FILL -> exactly 8 writes, in order, and no second refill.
REQ-025 reset_i asserted after beat 4 -> all outputs 0 next cycle, no refillDone_o; a new miss afterwards completes normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: miss-handler state encoding and cache line geometry.
package fetch_pkg;

  localparam int LINE_BEATS    = 8;
  localparam int BEAT_BYTES    = 8;
  localparam int LINE_OFFSET_W = $clog2(LINE_BEATS * BEAT_BYTES);

  typedef logic [2:0] miss_state_t;

  localparam miss_state_t ST_IDLE       = 3'd0;
  localparam miss_state_t ST_WAIT_STALL = 3'd1;
  localparam miss_state_t ST_REQ        = 3'd2;
  localparam miss_state_t ST_FILL       = 3'd3;
  localparam miss_state_t ST_DONE       = 3'd4;

  // Byte-offset bits inside one line for a given beat count and beat width.
  function automatic int line_offset_bits(input int beats, input int data_width);
    return $clog2(beats * (data_width / 8));
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Beat counter for one line refill, with a terminal-count flag on the final beat.
module refill_beat_counter
  import fetch_pkg::*;
#(
  parameter int  LINE_BEATS = fetch_pkg::LINE_BEATS,
  localparam int CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] beat_o,
  output logic             last_o
);

  logic [CNT_W-1:0] beat_d, beat_q;

  always_comb begin
    beat_d = beat_q;
    if (clear_i)    beat_d = '0;
    else if (inc_i) beat_d = beat_q + CNT_W'(1);
  end

  // NOTE: state flops use non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clock_i) begin
    if (reset_i) beat_q <= '0;
    else         beat_q <= beat_d;
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == CNT_W'(LINE_BEATS - 1));

endmodule

// File: rtl/fetch_miss_handler.sv
// Instruction-fetch miss handler: freezes fetch, requests one line from memory, writes it beat by beat.
module fetch_miss_handler
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = fetch_pkg::LINE_BEATS
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  tagMiss_i,
  input  logic [ADDR_WIDTH-1:0] missAddr_i,
  input  logic                  tagQueryStall_i,
  output logic                  fetchCacheMissStall_o,
  output logic                  memReq_o,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  input  logic                  memReqAck_i,
  input  logic                  memDataValid_i,
  input  logic [DATA_WIDTH-1:0] memData_i,
  output logic                  cacheWriteEn_o,
  output logic [ADDR_WIDTH-1:0] cacheWriteAddr_o,
  output logic [DATA_WIDTH-1:0] cacheWriteData_o,
  output logic                  refillDone_o
);

  localparam int CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OFFSET_W   = line_offset_bits(LINE_BEATS, DATA_WIDTH);
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));

  miss_state_t           state_d, state_q;
  logic [ADDR_WIDTH-1:0] line_addr_d, line_addr_q;
  logic                  cnt_clear, cnt_inc, cnt_last;
  logic [CNT_W-1:0]      beat_cnt;

  refill_beat_counter #(.LINE_BEATS(LINE_BEATS)) u_beat_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .beat_o  (beat_cnt),
    .last_o  (cnt_last)
  );

  // NOTE: every signal assigned here gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    line_addr_d    = line_addr_q;
    cnt_clear      = 1'b0;
    cnt_inc        = 1'b0;
    memReq_o       = 1'b0;
    cacheWriteEn_o = 1'b0;
    refillDone_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tagMiss_i) begin
          line_addr_d = missAddr_i & LINE_MASK;
          state_d     = ST_WAIT_STALL;
        end
      end
      ST_WAIT_STALL: begin
        if (tagQueryStall_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        memReq_o = 1'b1;
        if (memReqAck_i) begin
          cnt_clear = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        // Data beats are only honoured here; idle cycles between beats neither write nor count.
        if (memDataValid_i) begin
          cacheWriteEn_o = 1'b1;
          cnt_inc        = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        refillDone_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
    end
  end

  assign fetchCacheMissStall_o = (state_q == ST_WAIT_STALL) || (state_q == ST_REQ) ||
                                 (state_q == ST_FILL);
  assign memAddr_o        = memReq_o ? line_addr_q : '0;
  assign cacheWriteAddr_o = cacheWriteEn_o ?
                            line_addr_q + (ADDR_WIDTH'(beat_cnt) << BEAT_SHIFT) : '0;
  assign cacheWriteData_o = cacheWriteEn_o ? memData_i : '0;

endmodule

// File: tb/tb_fetch_miss_handler.sv
// Scoreboard bench for fetch_miss_handler: stimulus queues expected writes/done pulses, a monitor checks them.
module tb_fetch_miss_handler;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        tagMiss_i = 1'b0;
  logic [63:0] missAddr_i = '0;
  logic        tagQueryStall_i = 1'b0;
  logic        fetchCacheMissStall_o;
  logic        memReq_o;
  logic [63:0] memAddr_o;
  logic        memReqAck_i = 1'b0;
  logic        memDataValid_i = 1'b0;
  logic [63:0] memData_i = '0;
  logic        cacheWriteEn_o;
  logic [63:0] cacheWriteAddr_o;
  logic [63:0] cacheWriteData_o;
  logic        refillDone_o;

  fetch_miss_handler dut (
    .clock_i               (clock_i),
    .reset_i               (reset_i),
    .tagMiss_i             (tagMiss_i),
    .missAddr_i            (missAddr_i),
    .tagQueryStall_i       (tagQueryStall_i),
    .fetchCacheMissStall_o (fetchCacheMissStall_o),
    .memReq_o              (memReq_o),
    .memAddr_o             (memAddr_o),
    .memReqAck_i           (memReqAck_i),
    .memDataValid_i        (memDataValid_i),
    .memData_i             (memData_i),
    .cacheWriteEn_o        (cacheWriteEn_o),
    .cacheWriteAddr_o      (cacheWriteAddr_o),
    .cacheWriteData_o      (cacheWriteData_o),
    .refillDone_o          (refillDone_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write or done pulse the DUT presents must match the head of its queue.
  initial begin
    forever begin
      @(negedge clock_i);
      if (cacheWriteEn_o) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(cacheWriteEn_o), 64'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write_addr", cacheWriteAddr_o, e.addr);
          check("write_data", cacheWriteData_o, e.data);
          check("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (refillDone_o) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'(refillDone_o), 64'd0);
        end else begin
          int d;
          d = exp_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clock_i);
    check({tag, "_stall"},  64'(fetchCacheMissStall_o), 64'd0);
    check({tag, "_memreq"}, 64'(memReq_o), 64'd0);
    check({tag, "_memaddr"}, memAddr_o, 64'd0);
    check({tag, "_wen"},    64'(cacheWriteEn_o), 64'd0);
    check({tag, "_waddr"},  cacheWriteAddr_o, 64'd0);
    check({tag, "_wdata"},  cacheWriteData_o, 64'd0);
    check({tag, "_done"},   64'(refillDone_o), 64'd0);
  endtask

  // One miss. line is the hand-computed line address; gap_at inserts gap_len idle FILL
  // cycles (with tagMiss_i pulsed) before that beat index; reset_after >= 0 resets after that many beats.
  task automatic refill(input string tag, input logic [63:0] addr, input logic [63:0] line,
                        input int stall_dly, input int ack_dly, input int gap_at,
                        input int gap_len, input int reset_after, output int latency);
    int t0;
    int gaps;
    int beat;
    latency = -1;
    tagMiss_i  = 1'b1;
    missAddr_i = addr;
    t0 = cyc;
    @(negedge clock_i);
    check({tag, "_idle_stall"}, 64'(fetchCacheMissStall_o), 64'd0);
    next_cycle();
    tagMiss_i  = 1'b0;
    missAddr_i = 64'hDEAD_BEEF_0000_0000;
    for (int i = 0; i < stall_dly; i++) begin
      @(negedge clock_i);
      check({tag, "_wait_stall"}, 64'(fetchCacheMissStall_o), 64'd1);
      check({tag, "_wait_noreq"}, 64'(memReq_o), 64'd0);
      next_cycle();
    end
    tagQueryStall_i = 1'b1;
    @(negedge clock_i);
    check({tag, "_wait_stall"}, 64'(fetchCacheMissStall_o), 64'd1);
    check({tag, "_wait_noreq"}, 64'(memReq_o), 64'd0);
    next_cycle();
    tagQueryStall_i = 1'b0;
    // REQ: stray data beats must not write, including the ack cycle.
    memDataValid_i = 1'b1;
    memData_i      = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i <= ack_dly; i++) begin
      memReqAck_i = (i == ack_dly);
      @(negedge clock_i);
      check({tag, "_req"},       64'(memReq_o), 64'd1);
      check({tag, "_req_addr"},  memAddr_o, line);
      check({tag, "_req_stall"}, 64'(fetchCacheMissStall_o), 64'd1);
      next_cycle();
    end
    memReqAck_i    = 1'b0;
    memDataValid_i = 1'b0;
    beat = 0;
    gaps = gap_len;
    while (beat < 8) begin
      if (beat == gap_at && gaps > 0) begin
        memDataValid_i = 1'b0;
        tagMiss_i      = 1'b1;
        missAddr_i     = 64'h2000_0000;
        gaps--;
      end else begin
        memDataValid_i = 1'b1;
        tagMiss_i      = 1'b0;
        memData_i      = {32'hC0DE_0000 | 32'(beat), line[31:0]};
        exp_wr.push_back('{addr: line + 64'(beat * 8), data: memData_i, cyc: cyc});
        beat++;
      end
      @(negedge clock_i);
      check({tag, "_fill_stall"}, 64'(fetchCacheMissStall_o), 64'd1);
      check({tag, "_fill_noreq"}, 64'(memReq_o), 64'd0);
      next_cycle();
      if (beat == reset_after) begin
        memDataValid_i = 1'b0;
        reset_i        = 1'b1;
        next_cycle();
        reset_i        = 1'b0;
        memDataValid_i = 1'b1;
        memData_i      = 64'h5555_5555_5555_5555;
        check_idle_outputs({tag, "_post_reset"});
        next_cycle();
        memDataValid_i = 1'b0;
        check_idle_outputs({tag, "_post_reset2"});
        next_cycle();
        return;
      end
    end
    memDataValid_i = 1'b0;
    tagMiss_i      = 1'b0;
    exp_done.push_back(cyc);
    latency = cyc - t0;
    @(negedge clock_i);
    check({tag, "_done_stall"}, 64'(fetchCacheMissStall_o), 64'd0);
    next_cycle();
    check_idle_outputs({tag, "_after"});
    next_cycle();
    check_idle_outputs({tag, "_after2"});
    next_cycle();
  endtask

  initial begin
    int lat;
    next_cycle();
    next_cycle();
    tagMiss_i      = 1'b1;
    missAddr_i     = 64'h1000_0044;
    memDataValid_i = 1'b1;
    memData_i      = 64'h1234;
    next_cycle();
    check_idle_outputs("reset");
    reset_i = 1'b0;
    tagMiss_i = 1'b0;
    memDataValid_i = 1'b0;
    next_cycle();
    check_idle_outputs("post_reset_idle");
    next_cycle();

    refill("b2b", 64'h1000_0044, 64'h1000_0040, 0, 0, -1, 0, -1, lat);
    check("b2b_latency", 64'(lat), 64'd11);

    refill("stall5", 64'h0000_0000_8000_01F8, 64'h0000_0000_8000_01C0, 5, 0, -1, 0, -1, lat);
    check("stall5_latency", 64'(lat), 64'd16);

    refill("ack4", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 0, 4, -1, 0, -1, lat);
    check("ack4_latency", 64'(lat), 64'd15);

    refill("gap", 64'h0000_1234_5678_9A80, 64'h0000_1234_5678_9A80, 0, 0, 4, 2, -1, lat);
    check("gap_latency", 64'(lat), 64'd13);

    refill("rst", 64'h0000_0000_4000_0030, 64'h0000_0000_4000_0000, 0, 0, -1, 0, 4, lat);

    refill("after_rst", 64'h0000_0000_4000_0070, 64'h0000_0000_4000_0040, 1, 2, -1, 0, -1, lat);
    check("after_rst_latency", 64'(lat), 64'd14);

    repeat (3) next_cycle();
    check("pending_writes", 64'(exp_wr.size()), 64'd0);
    check("pending_done", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
